// File: rtl/pushbutton_conditioner_pkg.sv
// Purpose: shared types, default parameters and width helper for the
//          pushbutton conditioner (package pbc_pkg).
// Contents: pbc_state_t per-bit debounce state, default-parameter
//           localparams, cnt_width() counter-width helper.
package pbc_pkg;

    localparam int unsigned PBC_WIDTH           = 4;
    localparam int unsigned PBC_DEBOUNCE_CYCLES = 16;
    localparam int unsigned PBC_REPEAT_CYCLES   = 256;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } pbc_state_t;

    // Width of a counter that must hold values 0 .. n-1; never below 1 bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pushbutton_conditioner_if.sv
// Purpose: button/read-port bundle between the Nibbler IN port logic
//          (master) and the pushbutton conditioner (slave).
// Signals:
//   buttons_raw   master->slave  raw asynchronous buttons, 1 = pressed
//   ack           master->slave  read strobe (oeIN), clears sticky flags
//   pb_out        slave->master  sticky press flags
//   buttons_level slave->master  debounced button level
//   event_pending slave->master  OR of pb_out
interface pushbutton_conditioner_if
    import pbc_pkg::*;
#(
    parameter int unsigned WIDTH = PBC_WIDTH
);
    logic [WIDTH-1:0] buttons_raw;
    logic             ack;
    logic [WIDTH-1:0] pb_out;
    logic [WIDTH-1:0] buttons_level;
    logic             event_pending;

    modport master (
        output buttons_raw,
        output ack,
        input  pb_out,
        input  buttons_level,
        input  event_pending
    );

    modport slave (
        input  buttons_raw,
        input  ack,
        output pb_out,
        output buttons_level,
        output event_pending
    );
endinterface

// File: rtl/pushbutton_conditioner_debounce_bit.sv
// Purpose: one button lane - 2-FF synchroniser, debounce FSM and counter,
//          optional auto-repeat counter.
// Config:  PBC_AUTOREPEAT_EN enables the auto-repeat counter.
// Ports:
//   clock   in  system clock, rising edge
//   reset   in  asynchronous active-high reset
//   raw     in  raw asynchronous button
//   level   out debounced level (registered)
//   rise_c  out combinational one-cycle pulse at the edge a press is
//               accepted (and at each auto-repeat); consumed by the
//               sticky-flag register in the same edge
module pbc_debounce_bit
    import pbc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = PBC_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = PBC_REPEAT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise_c
);

    localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync;
    pbc_state_t    state;
    pbc_state_t    state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          level_next;
    logic          repeat_fire_c;

    // Two-stage synchroniser for the asynchronous button input.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync      <= sync_meta;
        end
    end

    // Debounce state, counter and level register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RELEASED;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            level <= level_next;
        end
    end

    // Next-state logic: a change is accepted after DEBOUNCE_CYCLES
    // consecutive synced samples at the new value.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        level_next = level;
        rise_c     = 1'b0;
        case (state)
            RELEASED: begin
                if (sync) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    level_next = 1'b1;
                    rise_c     = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (!sync) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = CW'(1);
                end else if (repeat_fire_c) begin
                    rise_c = 1'b1;
                end
            end
            RELEASE_WAIT: begin
                if (sync) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                    level_next = 1'b0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = RELEASED;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef PBC_AUTOREPEAT_EN
    localparam int unsigned   RW       = cnt_width(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep;
    logic [RW-1:0] rep_next;

    // Repeat counter runs only while held in PRESSED; anything else clears it.
    always_comb begin
        rep_next      = '0;
        repeat_fire_c = 1'b0;
        if (state == PRESSED && sync) begin
            if (rep == REP_LAST) begin
                repeat_fire_c = 1'b1;
            end else begin
                rep_next = rep + RW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rep <= '0;
        end else begin
            rep <= rep_next;
        end
    end
`else
    logic unused_repeat_cycles;
    assign unused_repeat_cycles = ^REPEAT_CYCLES;
    assign repeat_fire_c        = 1'b0;
`endif

endmodule

// File: rtl/pushbutton_conditioner.sv
// Purpose: Nibbler IN-port front end. Debounces WIDTH raw pushbuttons and
//          latches each accepted press in a sticky flag until the port is
//          read (ack = oeIN), so polling software cannot miss a short press.
// Config:  PBC_AUTOREPEAT_EN adds auto-repeat of held buttons.
// Ports:
//   clock  in  system clock, rising edge
//   reset  in  asynchronous active-high reset
//   bus    pushbutton_conditioner_if.slave:
//          buttons_raw/ack in, pb_out/buttons_level/event_pending out
module pushbutton_conditioner
    import pbc_pkg::*;
#(
    parameter int unsigned WIDTH           = PBC_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = PBC_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = PBC_REPEAT_CYCLES
) (
    input logic                     clock,
    input logic                     reset,
    pushbutton_conditioner_if.slave bus
);

    logic [WIDTH-1:0] rise_c;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] flags;
    logic [WIDTH-1:0] flags_next_c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pbc_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_bit (
            .clock (clock),
            .reset (reset),
            .raw   (bus.buttons_raw[i]),
            .level (level[i]),
            .rise_c(rise_c[i])
        );
    end

    // Read clears the flags; a press landing on the same edge still sets.
    assign flags_next_c = (flags & ~{WIDTH{bus.ack}}) | rise_c;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flags             <= '0;
            bus.event_pending <= 1'b0;
        end else begin
            flags             <= flags_next_c;
            bus.event_pending <= |flags_next_c;
        end
    end

    assign bus.pb_out        = flags;
    assign bus.buttons_level = level;

endmodule

// File: tb/tb_pushbutton_conditioner.sv
module tb_pushbutton_conditioner;

    localparam int unsigned W = 4;
    localparam int unsigned D = 4;
    localparam int unsigned R = 8;
`ifdef PBC_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    pushbutton_conditioner_if #(.WIDTH(W)) bus ();

    pushbutton_conditioner #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    int vecs = 0;
    int errs = 0;

    // Reference model: a button's level flips once the last D synchronised
    // samples (raw delayed two clocks) all disagree with it.
    logic [W-1:0] m_s1, m_s2, m_level, m_flags;
    int           m_run  [W];
    int           m_held [W];
    bit           m_intr [W];

    function automatic void model_clear();
        m_s1 = '0; m_s2 = '0; m_level = '0; m_flags = '0;
        for (int i = 0; i < int'(W); i++) begin
            m_run[i] = 0; m_held[i] = 0; m_intr[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge(input logic [W-1:0] raw, input logic ack);
        logic [W-1:0] rise;
        logic         s;
        rise = '0;
        for (int i = 0; i < int'(W); i++) begin
            s = m_s2[i];
            if (s != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == int'(D)) begin
                    m_level[i] = s;
                    m_run[i]   = 0;
                    if (s) begin
                        rise[i]   = 1'b1;
                        m_held[i] = 0;
                        m_intr[i] = 1'b0;
                    end
                end
            end else begin
                m_run[i] = 0;
            end
            // Auto-repeat: every R uninterrupted held cycles after acceptance.
            if (AR && m_level[i] && !rise[i]) begin
                if (!s) begin
                    m_held[i] = 0;
                    m_intr[i] = 1'b1;
                end else if (m_intr[i]) begin
                    m_intr[i] = 1'b0;
                    m_held[i] = 0;
                end else begin
                    m_held[i]++;
                    if (m_held[i] == int'(R)) begin
                        rise[i]   = 1'b1;
                        m_held[i] = 0;
                    end
                end
            end
        end
        m_flags = (m_flags & ~{W{ack}}) | rise;
        m_s2    = m_s1;
        m_s1    = raw;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: update model at the edge, compare all outputs 1 time unit later.
    task automatic tick();
        @(posedge clock);
        if (reset) model_clear();
        else model_edge(bus.buttons_raw, bus.ack);
        #1;
        check("pb_out", 32'(bus.pb_out), 32'(m_flags));
        check("level", 32'(bus.buttons_level), 32'(m_level));
        check("event", 32'(bus.event_pending), 32'(|m_flags));
    endtask

    // Asynchronous reset between edges; outputs must clear before the next edge.
    task automatic do_reset(input int n);
        #2;
        reset = 1'b1;
        #1;
        check("rst_pb_out", 32'(bus.pb_out), 32'h0);
        check("rst_level", 32'(bus.buttons_level), 32'h0);
        check("rst_event", 32'(bus.event_pending), 32'h0);
        model_clear();
        repeat (n) tick();
        reset = 1'b0;
    endtask

    initial begin
        bus.buttons_raw = '0;
        bus.ack         = 1'b0;
        model_clear();
        repeat (3) tick();
        reset = 1'b0;
        repeat (4) tick();

        // Clean press on bit 0: level appears on the 6th edge of stable input.
        bus.buttons_raw[0] = 1'b1;
        repeat (5) tick();
        check("press_early", 32'(bus.buttons_level[0]), 32'h0);
        tick();
        check("press_level", 32'(bus.buttons_level[0]), 32'h1);
        check("press_pb", 32'(bus.pb_out), 32'h1);
        check("press_evt", 32'(bus.event_pending), 32'h1);

        // Glitch on bit 1, three cycles long.
        bus.buttons_raw[1] = 1'b1;
        repeat (3) tick();
        bus.buttons_raw[1] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("glitch_lvl", 32'(bus.buttons_level[1]), 32'h0);
            check("glitch_pb", 32'(bus.pb_out), 32'h1);
        end

        // Ack on the very edge bit 2 completes its debounce.
        bus.buttons_raw[2] = 1'b1;
        repeat (5) tick();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("collide_pb", 32'(bus.pb_out), 32'h4);

        // Release of bit 0: level drops, flags untouched.
        bus.buttons_raw[0] = 1'b0;
        repeat (5) tick();
        check("rel_early", 32'(bus.buttons_level[0]), 32'h1);
        tick();
        check("rel_level", 32'(bus.buttons_level[0]), 32'h0);
        check("rel_pb", 32'(bus.pb_out), 32'h4);

        // Reset in the middle of bit 3's debounce; the held button re-debounces.
        bus.buttons_raw[3] = 1'b1;
        repeat (3) tick();
        do_reset(2);
        repeat (5) tick();
        check("mid_rst_early", 32'(bus.buttons_level[3]), 32'h0);
        tick();
        check("mid_rst_lvl", 32'(bus.buttons_level[3]), 32'h1);
        check("mid_rst_pb", 32'(bus.pb_out[3]), 32'h1);

        // Auto-repeat: clear, keep holding, flag returns R cycles after press.
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("rep_cleared", 32'(bus.pb_out[3]), 32'h0);
        repeat (6) tick();
        check("rep_early", 32'(bus.pb_out[3]), 32'h0);
        tick();
        check("rep_fire", 32'(bus.pb_out[3]), 32'(AR));

        // Held ack across a press completion.
        bus.buttons_raw = '0;
        repeat (8) tick();
        bus.ack = 1'b1;
        bus.buttons_raw[1] = 1'b1;
        repeat (8) tick();
        bus.ack = 1'b0;
        tick();

        // Randomised phases: fast bouncing, then long holds.
        for (int k = 0; k < 800; k++) begin
            for (int b = 0; b < int'(W); b++)
                if ($urandom_range(0, 5) == 0) bus.buttons_raw[b] = ~bus.buttons_raw[b];
            bus.ack = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 299) == 0) do_reset(1);
            else tick();
        end
        for (int k = 0; k < 1500; k++) begin
            for (int b = 0; b < int'(W); b++)
                if ($urandom_range(0, 39) == 0) bus.buttons_raw[b] = ~bus.buttons_raw[b];
            bus.ack = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) do_reset(1);
            else tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
